// File: rtl/seq_pattern_detector_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// The helpers build the KMP transition table from the pattern itself.
package seqdet_pkg;

   localparam int MAX_PAT_W = 16;

   // Longest prefix of pattern that is also a suffix of (first s pattern bits, then b),
   // capped below pat_w so a full match folds back onto the pattern border.
   function automatic int seqdet_next(input int s, input logic b,
                                      input logic [MAX_PAT_W-1:0] pattern, input int pat_w);
      int   best;
      int   idx;
      logic ok;
      logic str_bit;
      best = 0;
      for (int k = 1; k <= MAX_PAT_W; k++) begin
         if ((k <= s + 1) && (k < pat_w)) begin
            ok = 1'b1;
            for (int i = 0; i < MAX_PAT_W; i++) begin
               if (i < k) begin
                  idx     = s + 1 - k + i;
                  str_bit = (idx == s) ? b : pattern[pat_w - 1 - idx];
                  if (str_bit != pattern[pat_w - 1 - i]) begin
                     ok = 1'b0;
                  end
               end
            end
            if (ok) begin
               best = k;
            end
         end
      end
      return best;
   endfunction

   function automatic int seqdet_border(input logic [MAX_PAT_W-1:0] pattern, input int pat_w);
      return seqdet_next(pat_w - 1, pattern[0], pattern, pat_w);
   endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Serial-in / status-out bundle between a bit source (master) and the detector (slave).
interface seq_pattern_detector_if #(
   parameter int CNT_W = 8,
   parameter int ST_W  = 2
);
   logic             in_valid;
   logic             In;
   logic             clear;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic [ST_W-1:0]  state;

   modport master (output in_valid, In, clear, input match, match_count, state);
   modport slave  (input in_valid, In, clear, output match, match_count, state);
endinterface

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter; clr takes priority over inc, the count holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear first, then increment unless saturated
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {W{1'b0}};
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;
endmodule

// File: rtl/seq_pattern_detector.sv
// Parametrised serial pattern detector: KMP prefix tracking, registered match pulse,
// saturating match counter.
module seq_pattern_detector
   import seqdet_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter bit               OVERLAP = 1'b1,
   parameter int               CNT_W   = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   seq_pattern_detector_if.slave bus
);
   localparam int                   ST_W    = $clog2(PAT_W);
   localparam logic [MAX_PAT_W-1:0] PAT_EXT = MAX_PAT_W'(PATTERN);

   logic [ST_W-1:0] nxt_tab [PAT_W][2];
   logic            cmp_tab [PAT_W][2];
   logic [ST_W-1:0] state_q;
   logic [ST_W-1:0] state_d;
   logic            match_q;
   logic            match_d;

   // Per (state, bit) constants: next prefix length and whether the bit completes the pattern
   for (genvar gs = 0; gs < PAT_W; gs++) begin : g_st
      for (genvar gb = 0; gb < 2; gb++) begin : g_bit
         localparam bit DONE = (gs == PAT_W - 1) && (gb == int'(PATTERN[0]));
         localparam int NXT  = DONE ? (OVERLAP ? seqdet_border(PAT_EXT, PAT_W) : 0)
                                    : seqdet_next(gs, (gb == 1), PAT_EXT, PAT_W);
         assign nxt_tab[gs][gb] = ST_W'(NXT);
         assign cmp_tab[gs][gb] = DONE;
      end
   end

   // Only a qualified bit moves the prefix length; idle cycles hold it and drop the pulse
   always_comb begin
      state_d = state_q;
      match_d = 1'b0;
      if (bus.in_valid) begin
         state_d = nxt_tab[state_q][bus.In];
         match_d = cmp_tab[state_q][bus.In];
      end else begin
         state_d = state_q;
         match_d = 1'b0;
      end
   end

   // Prefix-length and match-pulse registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= {ST_W{1'b0}};
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_match_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (match_d),
      .clr   (bus.clear),
      .q     (bus.match_count)
   );

   assign bus.state = state_q;
   assign bus.match = match_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: three variants (overlap, non-overlap, 2-bit counter)
// fed the same stream and compared to a bit-history reference model.
module tb_seq_pattern_detector;
   localparam logic [3:0] PAT = 4'b1011;
   localparam int         PW  = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   seq_pattern_detector_if #(.CNT_W(8), .ST_W(2)) if_a ();
   seq_pattern_detector_if #(.CNT_W(8), .ST_W(2)) if_b ();
   seq_pattern_detector_if #(.CNT_W(2), .ST_W(2)) if_c ();

   seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
      .clock(clock), .reset(reset), .bus(if_a));
   seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
      .clock(clock), .reset(reset), .bus(if_b));
   seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
      .clock(clock), .reset(reset), .bus(if_c));

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] hist   [3];
   int          hlen   [3];
   int          mcnt   [3];
   int          mst    [3];
   int          mmatch [3];
   int          ovl    [3] = '{1, 0, 1};
   int          cmax   [3] = '{255, 255, 3};

   logic t1_bits [7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic t3_bits [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   int   t3_st   [6]  = '{1, 2, 3, 2, 3, 1};
   logic t4_bits [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
   int   t4_st   [4]  = '{1, 2, 3, 1};
   logic t6_bits [16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                          1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic b, input logic c);
      if_a.in_valid = v; if_a.In = b; if_a.clear = c;
      if_b.in_valid = v; if_b.In = b; if_b.clear = c;
      if_c.in_valid = v; if_c.In = b; if_c.clear = c;
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         hist[d] = 32'd0; hlen[d] = 0; mcnt[d] = 0; mst[d] = 0; mmatch[d] = 0;
      end
   endtask

   // Reference: keep the accepted bit history; a match is the last PW bits equal to PAT,
   // the state is the longest history suffix (shorter than PW) equal to a PAT prefix.
   task automatic model_edge(input logic v, input logic b, input logic c);
      for (int d = 0; d < 3; d++) begin
         mmatch[d] = 0;
         if (v) begin
            hist[d] = {hist[d][30:0], b};
            if (hlen[d] < 32) hlen[d]++;
            if (hlen[d] >= PW && hist[d][3:0] == PAT) begin
               mmatch[d] = 1;
               if (mcnt[d] < cmax[d]) mcnt[d]++;
               if (ovl[d] == 0) begin
                  hist[d] = 32'd0;
                  hlen[d] = 0;
               end
            end
            mst[d] = 0;
            for (int k = 1; k < PW; k++) begin
               if (k <= hlen[d] && ((hist[d] & ((32'd1 << k) - 32'd1)) == (32'(PAT) >> (PW - k))))
                  mst[d] = k;
            end
         end
         if (c) mcnt[d] = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_a_match"}, 32'(if_a.match),       32'(mmatch[0]));
      chk({tag, "_a_state"}, 32'(if_a.state),       32'(mst[0]));
      chk({tag, "_a_cnt"},   32'(if_a.match_count), 32'(mcnt[0]));
      chk({tag, "_b_match"}, 32'(if_b.match),       32'(mmatch[1]));
      chk({tag, "_b_state"}, 32'(if_b.state),       32'(mst[1]));
      chk({tag, "_b_cnt"},   32'(if_b.match_count), 32'(mcnt[1]));
      chk({tag, "_c_match"}, 32'(if_c.match),       32'(mmatch[2]));
      chk({tag, "_c_state"}, 32'(if_c.state),       32'(mst[2]));
      chk({tag, "_c_cnt"},   32'(if_c.match_count), 32'(mcnt[2]));
   endtask

   task automatic step(input logic v, input logic b, input logic c, input string tag);
      @(negedge clock);
      drive(v, b, c);
      @(posedge clock);
      model_edge(v, b, c);
      #1;
      check_all(tag);
   endtask

   // Assert reset between edges, check outputs at once, release on the falling edge
   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      model_reset();
      #1 check_all(tag);
      @(negedge clock);
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int nm;
      drive(1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge clock);
      #1 check_all("rst");
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         step(1'b1, t1_bits[i], 1'b0, "t1");
         chk("t1_match", 32'(if_a.match), 32'(i == 3 || i == 6));
      end
      chk("t1_cnt",   32'(if_a.match_count), 32'd2);
      chk("t2_state", 32'(if_b.state),       32'd1);
      chk("t2_cnt",   32'(if_b.match_count), 32'd1);

      async_reset("t3_rst");
      for (int i = 0; i < 6; i++) begin
         step(1'b1, t3_bits[i], 1'b0, "t3");
         chk("t3_state", 32'(if_a.state), 32'(t3_st[i]));
         chk("t3_match", 32'(if_a.match), 32'(i == 5));
      end

      async_reset("t4_rst");
      for (int i = 0; i < 4; i++) begin
         step(1'b1, t4_bits[i], 1'b0, "t4");
         chk("t4_match", 32'(if_a.match), 32'(i == 3));
         for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'bx, 1'b0, "t4_gap");
            chk("t4_gap_state", 32'(if_a.state), 32'(t4_st[i]));
            chk("t4_gap_match", 32'(if_a.match), 32'd0);
         end
      end

      async_reset("t5_pre");
      step(1'b1, 1'b1, 1'b0, "t5");
      step(1'b1, 1'b0, 1'b0, "t5");
      step(1'b1, 1'b1, 1'b0, "t5");
      async_reset("t5_mid");
      chk("t5_zero_state", 32'(if_a.state), 32'd0);
      step(1'b1, 1'b1, 1'b0, "t5_post");
      chk("t5_state", 32'(if_a.state), 32'd1);
      chk("t5_match", 32'(if_a.match), 32'd0);

      async_reset("t6_rst");
      nm = 0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, t6_bits[i], 1'b0, "t6");
         if (i % 3 == 0 && i > 0) begin
            nm++;
            chk("t6_cnt", 32'(if_c.match_count), 32'((nm > 3) ? 3 : nm));
         end
      end
      step(1'b1, 1'b0, 1'b0, "t6");
      step(1'b1, 1'b1, 1'b0, "t6");
      step(1'b1, 1'b1, 1'b1, "t6_clr");
      chk("t6_clr_cnt",   32'(if_c.match_count), 32'd0);
      chk("t6_clr_match", 32'(if_c.match),       32'd1);

      async_reset("rnd_start");
      for (int i = 0; i < 1500; i++) begin
         logic v;
         logic b;
         logic c;
         v = ($urandom_range(0, 3) != 0);
         b = 1'($urandom_range(0, 1));
         c = ($urandom_range(0, 19) == 0);
         step(v, v ? b : 1'bx, c, "rnd");
         if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
